// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   uart_state_e      - serializer FSM state, 3-bit encoding
//   UART_IDLE_LVL     - line level while idle and during stop bits
//   UART_START_LVL    - line level of the start bit
//   uart_frame_cfg_t  - per-frame configuration, captured once per frame
//   even_parity()     - XOR of up to UART_MAX_DATA_W data bits
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    localparam int UART_MAX_DATA_W = 9;

    typedef struct packed {
        logic parity_en;
        logic parity_odd;
        logic stop2;
    } uart_frame_cfg_t;

    // Narrower words are zero-extended by the caller; the extra zeros do not
    // change the XOR.
    function automatic logic even_parity(input logic [UART_MAX_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divisor counter.
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - capture div and restart the count at 0
//   run         - count while high; held at its value while low
//   div         - divisor; one bit period is div+1 cycles
//   bit_end     - high in the last cycle of each bit period
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    assign bit_end = run & (cnt_q == div_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            // load wins over the wrap so a back-to-back frame restarts at 0
            div_q <= div;
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= bit_end ? '0 : cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: drains a prefetch TX FIFO and serializes each word as
// start bit, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
//   clk, rst_n        - clock, synchronous active-low reset
//   tx_en             - allows new pops; a frame in flight always completes
//   baud_div          - bit period = baud_div+1 cycles (sampled at pop)
//   parity_en/_odd    - parity insertion and sense (sampled at pop)
//   stop2             - two stop bits when high (sampled at pop)
//   fifo_data/fifo_vld- FIFO head word and its valid
//   fifo_rd_en        - read enable towards the FIFO
//   txd               - registered serial line, idle high
//   tx_busy           - high from the cycle after a pop until the frame ends
//   frame_done        - pulse in the last cycle of the final stop bit
//   dbg_state         - current FSM state
//
// FIFO handshake: fifo_vld is the valid, fifo_rd_en the ready; a word
// transfers (pop) in any cycle where both are high. fifo_rd_en is built from
// registered state and tx_en only, so it never depends on fifo_vld and no
// combinational loop can form through the FIFO.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_vld,
    output logic              fifo_rd_en,
    output logic              txd,
    output logic              tx_busy,
    output logic              frame_done,
    output uart_state_e       dbg_state
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    uart_state_e      state_q, state_n;
    uart_frame_cfg_t  cfg_q;
    logic [DATA_W-1:0] shreg_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic             stop_idx_q;
    logic             par_even_q;
    logic             txd_q, txd_n;
    logic             shift_en;
    logic             bit_end;
    logic             pop;
    logic             stop_last;

    uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pop),
        .run     (state_q != IDLE),
        .div     (baud_div),
        .bit_end (bit_end)
    );

    // Final cycle of the final stop bit: the only in-frame cycle that may pop.
    assign stop_last  = (state_q == STOP) & bit_end & (stop_idx_q == cfg_q.stop2);
    assign fifo_rd_en = rst_n & tx_en & ((state_q == IDLE) | stop_last);
    assign pop        = fifo_vld & fifo_rd_en;

    assign txd        = txd_q;
    assign tx_busy    = (state_q != IDLE);
    assign frame_done = stop_last;
    assign dbg_state  = state_q;

    // txd_n is the line level for the next cycle, so txd is registered with
    // the state it belongs to.
    always_comb begin
        state_n  = state_q;
        txd_n    = txd_q;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                txd_n = UART_IDLE_LVL;
                if (pop) begin
                    state_n = START;
                    txd_n   = UART_START_LVL;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n  = DATA;
                    txd_n    = shreg_q[0];
                    shift_en = 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
                        if (cfg_q.parity_en) begin
                            state_n = PARITY;
                            txd_n   = par_even_q ^ cfg_q.parity_odd;
                        end else begin
                            state_n = STOP;
                            txd_n   = UART_IDLE_LVL;
                        end
                    end else begin
                        txd_n    = shreg_q[0];
                        shift_en = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    txd_n   = UART_IDLE_LVL;
                end
            end
            STOP: begin
                if (stop_last) begin
                    if (pop) begin
                        state_n = START;
                        txd_n   = UART_START_LVL;
                    end else begin
                        state_n = IDLE;
                        txd_n   = UART_IDLE_LVL;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = UART_IDLE_LVL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            txd_q      <= UART_IDLE_LVL;
            shreg_q    <= '0;
            cfg_q      <= '0;
            par_even_q <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q <= state_n;
            txd_q   <= txd_n;
            if (pop) begin
                // shreg_q[0] is always the next data bit to put on the line
                shreg_q    <= fifo_data;
                cfg_q      <= {parity_en, parity_odd, stop2};
                par_even_q <= even_parity(UART_MAX_DATA_W'(fifo_data));
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
            end else begin
                if (shift_en) begin
                    shreg_q <= shreg_q >> 1;
                end
                if ((state_q == DATA) && bit_end) begin
                    bit_idx_q <= bit_idx_q + IDX_W'(1);
                end
                if ((state_q == STOP) && bit_end && !stop_last) begin
                    stop_idx_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              tx_en;
  logic [DIV_W-1:0]  baud_div;
  logic              parity_en;
  logic              parity_odd;
  logic              stop2;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_vld;
  logic              fifo_rd_en;
  logic              txd;
  logic              tx_busy;
  logic              frame_done;
  uart_state_e       dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .fifo_data  (fifo_data),
    .fifo_vld   (fifo_vld),
    .fifo_rd_en (fifo_rd_en),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] src_q[$];      // words held in the FIFO model
  logic [15:0]       exp_q[$];      // expected line image, bit 0 first
  int                exp_len_q[$];  // expected frame length in bits
  int                exp_per_q[$];  // expected cycles per bit

  // Builds the expected frame from the current config and queues the word.
  task automatic push_word(input logic [DATA_W-1:0] d);
    logic [15:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) f[1+i] = d[i];
    n = 1 + DATA_W;
    if (parity_en) begin
      f[n] = (^d) ^ parity_odd;
      n++;
    end
    f[n] = 1'b1;
    n++;
    if (stop2) begin
      f[n] = 1'b1;
      n++;
    end
    src_q.push_back(d);
    exp_q.push_back(f);
    exp_len_q.push_back(n);
    exp_per_q.push_back(int'(baud_div) + 1);
  endtask

  // ---------------- FIFO driver ----------------
  initial begin : feeder
    logic pn;
    fifo_vld  = 1'b0;
    fifo_data = '0;
    forever begin
      @(negedge clk);
      pn = rst_n & fifo_vld & fifo_rd_en;
      @(posedge clk);
      #1;
      if (pn && src_q.size() != 0) void'(src_q.pop_front());
      fifo_vld  = (src_q.size() != 0);
      fifo_data = fifo_vld ? src_q[0] : DATA_W'($urandom);
    end
  end

  // ---------------- line monitor ----------------
  logic        in_frame = 1'b0;
  logic        pop_prev = 1'b0;
  logic        pop_m;
  logic        is_last;
  logic [15:0] cur_frame = '1;
  int          cur_len = 0, cur_per = 1, bit_i = 0, cyc_i = 0;
  int          frames_done = 0, pop_cnt = 0;
  int          last_pop = 0, last_done = 0, prev_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      pop_prev = 1'b0;
    end else begin
      if (!in_frame && pop_prev) begin
        check_eq("sb_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur_frame = exp_q.pop_front();
          cur_len   = exp_len_q.pop_front();
          cur_per   = exp_per_q.pop_front();
        end
        in_frame = 1'b1;
        bit_i = 0;
        cyc_i = 0;
      end
      if (in_frame) begin
        is_last = (bit_i == cur_len - 1) && (cyc_i == cur_per - 1);
        check_eq("txd_bit", 32'(txd), 32'(cur_frame[bit_i]));
        check_eq("busy_frame", 32'(tx_busy), 1);
        check_eq("frame_done", 32'(frame_done), 32'(is_last));
        check_eq("rd_en_frame", 32'(fifo_rd_en), 32'(tx_en & is_last));
        if (is_last) begin
          in_frame = 1'b0;
          frames_done++;
          prev_done = last_done;
          last_done = cyc;
        end else if (cyc_i == cur_per - 1) begin
          cyc_i = 0;
          bit_i++;
        end else begin
          cyc_i++;
        end
      end else begin
        check_eq("txd_idle", 32'(txd), 1);
        check_eq("busy_idle", 32'(tx_busy), 0);
        check_eq("done_idle", 32'(frame_done), 0);
        check_eq("rd_en_idle", 32'(fifo_rd_en), 32'(tx_en));
      end
      pop_m = fifo_vld & fifo_rd_en;
      if (pop_m) begin
        pop_cnt++;
        last_pop = cyc;
      end
      pop_prev = pop_m;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_frames(input int n);
    int target, waited;
    target = frames_done + n;
    waited = 0;
    while (frames_done < target && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("frame_wait", 32'(frames_done >= target), 1);
  endtask

  task automatic wait_pop();
    int target, waited;
    target = pop_cnt + 1;
    waited = 0;
    while (pop_cnt < target && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("pop_wait", 32'(pop_cnt >= target), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_txd"}, 32'(txd), 1);
    check_eq({tag, "_busy"}, 32'(tx_busy), 0);
    check_eq({tag, "_done"}, 32'(frame_done), 0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  int pc_saved;

  initial begin
    rst_n      = 1'b0;
    tx_en      = 1'b1;
    baud_div   = 16'd3;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;

    // reset state; rd_en must stay low even with tx_en high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    check_eq("rst_rd_en", 32'(fifo_rd_en), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single byte 0x55, 10 bits x 4 clk
    push_word(8'h55);
    wait_frames(1);
    check_eq("len_55", 32'(last_done - last_pop), 40);

    // back-to-back, zero gap, frame_done 20 cycles apart
    baud_div = 16'd1;
    push_word(8'hA5);
    push_word(8'h3C);
    wait_frames(2);
    check_eq("b2b_spacing", 32'(last_done - prev_done), 20);

    // parity even / odd, then two stop bits at 1 clk per bit
    baud_div  = 16'd0;
    parity_en = 1'b1;
    push_word(8'h07);
    wait_frames(1);
    parity_odd = 1'b1;
    push_word(8'h07);
    wait_frames(1);
    stop2 = 1'b1;
    push_word(8'h07);
    wait_frames(1);
    check_eq("len_12", 32'(last_done - last_pop), 12);

    // config changed right after the pop must not affect the frame
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    baud_div   = 16'd2;
    push_word(8'h81);
    wait_pop();
    baud_div  = 16'd0;
    parity_en = 1'b1;
    stop2     = 1'b1;
    wait_frames(1);
    check_eq("len_cfg_hold", 32'(last_done - last_pop), 30);
    parity_en = 1'b0;
    stop2     = 1'b0;

    // flow control: tx_en dropped during data bit 2 of 0xFF
    baud_div = 16'd1;
    push_word(8'hFF);
    wait_pop();
    repeat (6) @(posedge clk);
    #1 tx_en = 1'b0;
    push_word(8'h12);
    wait_frames(1);
    pc_saved = pop_cnt;
    repeat (10) @(posedge clk);
    #1;
    check_eq("flow_rd_en", 32'(fifo_rd_en), 0);
    check_eq("flow_held", 32'(src_q.size()), 1);
    check_eq("flow_no_pop", 32'(pop_cnt - pc_saved), 0);
    tx_en = 1'b1;
    wait_frames(1);

    // empty FIFO: line idle, no pops
    pc_saved = pop_cnt;
    repeat (12) @(posedge clk);
    #1;
    check_eq("empty_no_pop", 32'(pop_cnt - pc_saved), 0);

    // reset in the middle of a zero data bit
    baud_div = 16'd3;
    push_word(8'h00);
    wait_pop();
    repeat (5) @(posedge clk);
    #1;
    check_eq("pre_rst_txd", 32'(txd), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");

    // clean frame after reset
    push_word(8'h5A);
    wait_frames(1);
    check_eq("len_after_rst", 32'(last_done - last_pop), 40);

    repeat (4) @(posedge clk);
    #1;
    check_eq("sb_drained", 32'(exp_q.size()), 0);
    check_eq("fifo_drained", 32'(src_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
